// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker - self-synchronising x^4+x+1 PRBS receive checker with lock FSM
// Seeds from the line, hunts for LOCK_THRESH correct predictions, then flags and counts errors.
module lfsr_seq_checker #(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] TAPS          = 4'b1001,
    parameter int               LOCK_THRESH   = 8,
    parameter int               UNLOCK_THRESH = 4,
    parameter int               ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 bit_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int FILL_W  = $clog2(WIDTH);
    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int CERR_W  = $clog2(UNLOCK_THRESH + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CERR_W-1:0]    consec_err_q, consec_err_d;
    logic                 bit_err_q, bit_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 pred;
    logic [WIDTH-1:0]     sr_shift_in;
    logic [MATCH_W-1:0]   match_inc;
    logic [CERR_W-1:0]    consec_inc;

    assign pred        = ^(sr_q & TAPS);
    assign sr_shift_in = {sr_q[WIDTH-2:0], bit_in};
    assign match_inc   = match_cnt_q + MATCH_W'(1);
    assign consec_inc  = consec_err_q + CERR_W'(1);

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        fill_cnt_d   = fill_cnt_q;
        match_cnt_d  = match_cnt_q;
        consec_err_d = consec_err_q;
        bit_err_d    = 1'b0;
        err_count_d  = err_count_q;

        if (bit_valid) begin
            case (state_q)
                SEED: begin
                    sr_d       = sr_shift_in;
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
                        fill_cnt_d = '0;
                        if (sr_shift_in != '0) begin
                            state_d     = HUNT;
                            match_cnt_d = '0;
                        end
                    end
                end
                HUNT: begin
                    sr_d = sr_shift_in;
                    if (bit_in == pred) begin
                        match_cnt_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_THRESH)) begin
                            state_d      = LOCKED;
                            consec_err_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                    // An all-zero register would predict zeros forever; reseed instead.
                    if (sr_shift_in == '0) begin
                        state_d    = SEED;
                        fill_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so line errors do not corrupt the reference.
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (bit_in == pred) begin
                        consec_err_d = '0;
                    end else begin
                        bit_err_d    = 1'b1;
                        consec_err_d = consec_inc;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_CNT_W'(1);
                        end
                        if (consec_inc == CERR_W'(UNLOCK_THRESH)) begin
                            state_d    = SEED;
                            fill_cnt_d = '0;
                            sr_d       = '0;
                        end
                    end
                end
                default: begin
                    state_d    = SEED;
                    fill_cnt_d = '0;
                    sr_d       = '0;
                end
            endcase
        end

        if (err_clr) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q      <= SEED;
            sr_q         <= '0;
            fill_cnt_q   <= '0;
            match_cnt_q  <= '0;
            consec_err_q <= '0;
            bit_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            fill_cnt_q   <= fill_cnt_d;
            match_cnt_q  <= match_cnt_d;
            consec_err_q <= consec_err_d;
            bit_err_q    <= bit_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign bit_err   = bit_err_q;
    assign err_count = err_count_q;

endmodule
